// File: rtl/sram_dp_be.sv
// sram_dp_be: simple dual-port synchronous SRAM (one write port, one read port) with per-lane
// byte enables, a registered read with a valid strobe, and a clear sequencer that zeroes
// every implemented word after reset.
//
// Optional feature (compile-time macro SRAM_DP_WR_BYPASS_EN):
//   defined   - a same-address, same-edge read returns the merged word (write-first).
//   undefined - a same-address, same-edge read returns the pre-write contents (read-first).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   wr_cs      write-port chip select
//   wr_en      write enable (write when wr_cs & wr_en)
//   wr_addr    write address
//   wr_data    write data
//   wr_be      per-lane write enables, bit k covers [k*LANE_WIDTH +: LANE_WIDTH]
//   rd_cs      read-port chip select
//   rd_en      read enable (read when rd_cs & rd_en)
//   rd_addr    read address
//   rd_data    registered read data
//   rd_valid   one-cycle pulse when rd_data was updated by a read
//   init_busy  high while the clear sequencer runs; user accesses are ignored
module sram_dp_be #(
  parameter int unsigned ADDRESS_BITS = 5,
  parameter int unsigned NUM_REG      = 32,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned LANE_WIDTH   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_cs,
  input  logic                             wr_en,
  input  logic [ADDRESS_BITS-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_be,
  input  logic                             rd_cs,
  input  logic                             rd_en,
  input  logic [ADDRESS_BITS-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             init_busy
);

  localparam int unsigned NumLanes = DATA_WIDTH / LANE_WIDTH;
  // Index width of the implemented array; NUM_REG <= 2^ADDRESS_BITS keeps this <= ADDRESS_BITS.
  localparam int unsigned IdxW     = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

  localparam logic [IdxW-1:0]       LastIdx = IdxW'(NUM_REG - 1);
  localparam logic [ADDRESS_BITS:0] NumRegW = (ADDRESS_BITS + 1)'(NUM_REG);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REG];

  logic                  wr_in_range, rd_in_range;
  logic                  wr_do, rd_do;
  logic [IdxW-1:0]       wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < NumRegW);
    rd_in_range = ({1'b0, rd_addr} < NumRegW);
    wr_idx      = wr_addr[IdxW-1:0];
    rd_idx      = rd_addr[IdxW-1:0];
    wr_do       = (state_q == StReady) && wr_cs && wr_en && wr_in_range;
    rd_do       = (state_q == StReady) && rd_cs && rd_en;
    rd_word     = mem_q[rd_idx];
`ifdef SRAM_DP_WR_BYPASS_EN
    // Forward enabled lanes of a same-edge write to the same word.
    if (wr_do && (wr_addr == rd_addr)) begin
      for (int unsigned k = 0; k < NumLanes; k++) begin
        if (wr_be[k]) begin
          rd_word[k*LANE_WIDTH +: LANE_WIDTH] = wr_data[k*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
`endif
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      init_busy <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_q   <= StReady;
            init_busy <= 1'b0;
          end
        end
        StReady: begin
          if (rd_do) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_in_range ? rd_word : '0;
          end
        end
        default: begin
          state_q   <= StInit;
          cnt_q     <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; the clear sequencer zeroes it instead. A reset edge writes nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_do) begin
        for (int unsigned k = 0; k < NumLanes; k++) begin
          if (wr_be[k]) begin
            mem_q[wr_idx][k*LANE_WIDTH +: LANE_WIDTH] <= wr_data[k*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
- Parametrised successor to the single-port sram: a simple dual-port synchronous SRAM with one write port and one read port, both usable in the same cycle.
- Adds per-lane byte enables, a registered read with a valid strobe, and a hardware clear sequencer that zeroes every location after reset.
- Serves as the general-purpose local buffer and register-file store for the datapath blocks.

Parameters:
- ADDRESS_BITS, 5, address width of both ports.
- NUM_REG, 32, number of implemented words; must be ≤ 2^ADDRESS_BITS.
- DATA_WIDTH, 16, word width; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, bits per byte-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_cs  in  1  write-port chip select.
- wr_en  in  1  write enable; a write occurs when wr_cs & wr_en.
- wr_addr  in  ADDRESS_BITS  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  NUM_LANES  lane enables; bit k selects bits [k*LANE_WIDTH +: LANE_WIDTH].
- rd_cs  in  1  read-port chip select.
- rd_en  in  1  read enable; a read occurs when rd_cs & rd_en.
- rd_addr  in  ADDRESS_BITS  read address.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse, high in the cycle rd_data is updated by a read.
- init_busy  out  1  high while the clear sequencer runs; user accesses are ignored.

Behaviour:
- Reset: rst high at an edge sets rd_data=0, rd_valid=0, init_busy=1, FSM=INIT, clear counter=0. Memory contents are not touched during the reset edge.
- FSM INIT: each edge with rst=0 writes 0 to mem[cnt] and increments cnt.
  - The edge that clears mem[NUM_REG-1] moves the FSM to READY and drops init_busy.
  - init_busy is therefore high for exactly NUM_REG edges after rst releases.
- In INIT, all wr_* and rd_* requests are ignored, and rd_valid stays 0.
- FSM READY, write: when wr_cs & wr_en at an edge and wr_addr < NUM_REG, mem[wr_addr] lanes with wr_be=1 take wr_data. Other lanes keep their value. wr_be=0 is a legal no-op.
- FSM READY, read:
  - When rd_cs & rd_en at edge N, rd_data holds mem[rd_addr] and rd_valid=1 after edge N (latency 1).
  - With no read at an edge, rd_valid=0 and rd_data holds its last value.
- Out of range (addr ≥ NUM_REG):
  - A write is dropped.
  - A read returns rd_data=0 with rd_valid=1.
- Read and write to different addresses in the same edge proceed independently.
- Read and write to the same address in the same edge: result is set by the Optional Feature section.
- Reset mid-operation: rst high in any state aborts the current access and clears pending rd_valid. The full clear sequence restarts after release.
- Address arithmetic: there is no auto-increment and no wrap logic; addresses are used as presented.

Optional Feature:
- Macro: SRAM_DP_WR_BYPASS_EN.
- Defined: a same-address, same-edge read returns the merged word. Lanes with wr_be=1 carry the new wr_data; other lanes carry the old contents. This is write-first behaviour.
- Undefined: a same-address read returns the full pre-write contents (read-first). The write still commits at that edge.

Test Plan:
- Reset/init: assert rst 2 cycles, release. Required: init_busy high for exactly 32 edges, then low. A read of every address 0..31 then returns 16'h0000 with rd_valid=1.
- Sequential fill/readback: write addr i with data 3*i for i=0..31, wr_be=2'b11. Then read addresses 31 down to 0. Required: each rd_data equals 3*addr one cycle after the request, and rd_valid is pulsed each cycle.
- Byte enables: write 16'hA5A5 to addr 4 with be=11, then 16'h3C3C with be=01. Required: a read of addr 4 returns 16'hA53C.
- Same-address collision: mem[7]=16'h1111. Issue a write of 16'h2222 (be=11) and a read of addr 7 on the same edge. Required: rd_data=16'h2222 with SRAM_DP_WR_BYPASS_EN, 16'h1111 without. A following read returns 16'h2222 in both builds.
- Access during init and mid-op reset: issue a write and a read while init_busy=1. Required: no rd_valid, and the location reads 0 after init. Assert rst while a read is issued. Required: rd_valid=0, rd_data=0, and init_busy is high again for 32 edges.
- Out of range and ignored lanes: with NUM_REG=20, write addr 25, then read addr 25. Required: rd_data=0 with rd_valid=1, and mem[0..19] are unchanged. A write with wr_be=00 leaves its target unchanged.
